// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: grant encoding
// and register-index constants.
package wb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LLU  = 2'd2
    } gnt_e;

    // x0 is hardwired zero: never written, never marked busy
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / LLU (master side) and the write-port
// arbiter (slave side), including the register-file write port and busy map.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;

    logic              llu_valid;
    logic [ADDR_W-1:0] llu_waddr;
    logic [DATA_W-1:0] llu_wdata;
    logic              llu_ready;
    logic              llu_issue;
    logic [ADDR_W-1:0] llu_issue_rd;

    logic [NREG-1:0]   rd_busy;
    logic              rd_wr_en;
    logic [ADDR_W-1:0] rd_waddr;
    logic [DATA_W-1:0] rd_wdata;

    modport slave (
        input  pipe_wr_en, pipe_waddr, pipe_wdata,
        input  llu_valid, llu_waddr, llu_wdata, llu_issue, llu_issue_rd,
        output pipe_stall, llu_ready, rd_busy, rd_wr_en, rd_waddr, rd_wdata
    );

    modport master (
        output pipe_wr_en, pipe_waddr, pipe_wdata,
        output llu_valid, llu_waddr, llu_wdata, llu_issue, llu_issue_rd,
        input  pipe_stall, llu_ready, rd_busy, rd_wr_en, rd_waddr, rd_wdata
    );

endinterface

// File: rtl/wb_port_arbiter_scoreboard.sv
// Busy bitmap of registers waiting on an LLU result. A set and a clear of the
// same register in one cycle leaves it set (a newer LLU op targets it again).
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_set_en,
    input  logic [ADDR_W-1:0]      i_set_idx,
    input  logic                   i_clr_en,
    input  logic [ADDR_W-1:0]      i_clr_idx,
    output logic [(1<<ADDR_W)-1:0] o_busy
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            for (int r = REG_ZERO + 1; r < NREG; r++) begin
                if (i_set_en && (i_set_idx == ADDR_W'(r)))
                    r_busy[r] <= 1'b1;
                else if (i_clr_en && (i_clr_idx == ADDR_W'(r)))
                    r_busy[r] <= 1'b0;
            end
            r_busy[REG_ZERO] <= 1'b0;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and the
// LLU; pipeline has priority until an LLU result has waited STARVE_LIMIT cycles.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    gnt_e              w_gnt;
    logic              w_pipe_req;
    logic              w_llu_req;
    logic              w_force;
    logic              w_llu_hs;
    logic [NREG-1:0]   w_busy;

    assign w_pipe_req = bus.pipe_wr_en && (bus.pipe_waddr != ADDR_W'(REG_ZERO));
    assign w_llu_req  = bus.llu_valid;
    assign w_force    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_force && w_llu_req)
            w_gnt = GNT_LLU;
        else if (w_pipe_req)
            w_gnt = GNT_PIPE;
        else if (w_llu_req)
            w_gnt = GNT_LLU;
    end

    // Handshakes are suppressed during reset so nothing is consumed by a dying state
    assign bus.llu_ready  = !i_rst && (w_gnt == GNT_LLU);
    assign bus.pipe_stall = !i_rst && w_pipe_req && (w_gnt == GNT_LLU);
    assign w_llu_hs       = w_llu_req && bus.llu_ready;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (w_llu_req && (w_gnt != GNT_LLU)) begin
            if (!w_force)
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Address/data hold when idle; only the enable drops
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_wr_en <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (w_gnt)
                GNT_PIPE: begin
                    r_wr_en <= 1'b1;
                    r_waddr <= bus.pipe_waddr;
                    r_wdata <= bus.pipe_wdata;
                end
                GNT_LLU: begin
                    r_wr_en <= (bus.llu_waddr != ADDR_W'(REG_ZERO));
                    r_waddr <= bus.llu_waddr;
                    r_wdata <= bus.llu_wdata;
                end
                default: r_wr_en <= 1'b0;
            endcase
        end
    end

    assign bus.rd_wr_en = r_wr_en;
    assign bus.rd_waddr = r_waddr;
    assign bus.rd_wdata = r_wdata;

    wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .i_clk     (i_sys_clk),
        .i_rst     (i_rst),
        .i_set_en  (bus.llu_issue),
        .i_set_idx (bus.llu_issue_rd),
        .i_clr_en  (w_llu_hs),
        .i_clr_idx (bus.llu_waddr),
        .o_busy    (w_busy)
    );

    assign bus.rd_busy = w_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: two arbiters (STARVE_LIMIT 4 and 0) share one stimulus
// stream; a reference model predicts each cycle and a monitor compares.
module tb_wb_port_arbiter;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst = 1'b1;
    logic        d_pwe = 1'b0;
    logic [4:0]  d_pa  = '0;
    logic [31:0] d_pd  = '0;
    logic        d_lv  = 1'b0;
    logic [4:0]  d_la  = '0;
    logic [31:0] d_ld  = '0;
    logic        d_iss = 1'b0;
    logic [4:0]  d_ird = '0;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if4 ();
    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if0 ();

    assign if4.pipe_wr_en = d_pwe;  assign if0.pipe_wr_en = d_pwe;
    assign if4.pipe_waddr = d_pa;   assign if0.pipe_waddr = d_pa;
    assign if4.pipe_wdata = d_pd;   assign if0.pipe_wdata = d_pd;
    assign if4.llu_valid  = d_lv;   assign if0.llu_valid  = d_lv;
    assign if4.llu_waddr  = d_la;   assign if0.llu_waddr  = d_la;
    assign if4.llu_wdata  = d_ld;   assign if0.llu_wdata  = d_ld;
    assign if4.llu_issue  = d_iss;  assign if0.llu_issue  = d_iss;
    assign if4.llu_issue_rd = d_ird; assign if0.llu_issue_rd = d_ird;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .CNT_W(3)) dut4 (
        .i_sys_clk (clk),
        .i_rst     (d_rst),
        .bus       (if4.slave)
    );

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(0), .CNT_W(3)) dut0 (
        .i_sys_clk (clk),
        .i_rst     (d_rst),
        .bus       (if0.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: waited cycles, busy set, last write address/data
    int          m_wait [2];
    logic [31:0] m_busy [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];

    logic last_stall = 1'b0;
    logic last_rdy   = 1'b0;

    function automatic exp_t model(input int k);
        exp_t e;
        int   lim;
        logic preq, gl;
        lim = (k == 0) ? 4 : 0;
        if (d_rst) begin
            m_wait[k] = 0; m_busy[k] = '0; m_addr[k] = '0; m_data[k] = '0;
            e.stall = 1'b0; e.ready = 1'b0; e.wr = 1'b0;
        end else begin
            preq = d_pwe && (d_pa != 5'd0);
            gl   = d_lv && ((m_wait[k] >= lim) || !preq);
            e.stall = preq && gl;
            e.ready = gl;
            if (d_lv && !gl) m_wait[k] = (m_wait[k] + 1 > lim) ? lim : m_wait[k] + 1;
            else             m_wait[k] = 0;
            if (gl) begin
                e.wr = (d_la != 5'd0); m_addr[k] = d_la; m_data[k] = d_ld;
                m_busy[k][d_la] = 1'b0;
            end else if (preq) begin
                e.wr = 1'b1; m_addr[k] = d_pa; m_data[k] = d_pd;
            end else begin
                e.wr = 1'b0;
            end
            if (d_iss && d_ird != 5'd0) m_busy[k][d_ird] = 1'b1;
        end
        e.addr = m_addr[k];
        e.data = m_data[k];
        e.busy = m_busy[k];
        return e;
    endfunction

    task automatic drive(input logic rst, input logic pwe, input logic [4:0] pa,
                         input logic [31:0] pd, input logic lv, input logic [4:0] la,
                         input logic [31:0] ld, input logic iss, input logic [4:0] ird);
        exp_t e0, e1;
        @(negedge clk);
        d_rst = rst; d_pwe = pwe; d_pa = pa; d_pd = pd;
        d_lv = lv; d_la = la; d_ld = ld; d_iss = iss; d_ird = ird;
        e0 = model(0);
        e1 = model(1);
        q0.push_back(e0);
        q1.push_back(e1);
        last_stall = e0.stall | e1.stall;
        last_rdy   = e0.ready;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: handshake outputs mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e0, e1;
        forever begin
            @(negedge clk);
            #2;
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("L4 stall", 32'(if4.pipe_stall), 32'(e0.stall));
                chk("L4 ready", 32'(if4.llu_ready),  32'(e0.ready));
                chk("L0 stall", 32'(if0.pipe_stall), 32'(e1.stall));
                chk("L0 ready", 32'(if0.llu_ready),  32'(e1.ready));
                @(posedge clk);
                #1;
                chk("L4 wr_en", 32'(if4.rd_wr_en), 32'(e0.wr));
                chk("L4 waddr", 32'(if4.rd_waddr), 32'(e0.addr));
                chk("L4 wdata", if4.rd_wdata, e0.data);
                chk("L4 busy",  if4.rd_busy,  e0.busy);
                chk("L0 wr_en", 32'(if0.rd_wr_en), 32'(e1.wr));
                chk("L0 waddr", 32'(if0.rd_waddr), 32'(e1.addr));
                chk("L0 wdata", if0.rd_wdata, e1.data);
                chk("L0 busy",  if0.rd_busy,  e1.busy);
            end
        end
    end

    initial begin
        logic        done;
        logic [4:0]  pa, rla, rpa;
        logic [31:0] rpd, rld;
        logic        rpwe, rlv;

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pipe-only write, then idle (address/data hold)
        drive(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Pipe x0 alone, then pipe x0 against LLU x7
        drive(0, 1, 5'd0, 32'hdead, 0, 0, 0, 0, 0);
        drive(0, 1, 5'd0, 32'hbeef, 1, 5'd7, 32'h7777, 0, 0);

        // Starvation: pipe every cycle, LLU x9 held until accepted
        done = 1'b0;
        pa   = 5'd10;
        for (int i = 0; i < 7; i++) begin
            if (!last_stall && i > 0) pa = pa + 5'd1;
            drive(0, 1, pa, {27'd0, pa}, !done, 5'd9, 32'h9999, 0, 0);
            if (last_rdy) done = 1'b1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Busy scoreboard: set, clear by handshake, set-wins on collision
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
        drive(0, 0, 0, 0, 1, 5'd12, 32'hc0c0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
        drive(0, 0, 0, 0, 1, 5'd12, 32'hc1c1, 1, 5'd12);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
        drive(0, 0, 0, 0, 1, 5'd0, 32'h0000_0abc, 0, 0);

        // LLU x3 against pipe x4; then reset lands on the forced-grant cycle
        drive(0, 1, 5'd4, 32'h4444, 1, 5'd3, 32'h3333, 0, 0);
        drive(0, 1, 5'd4, 32'h4444, 0, 0, 0, 1, 5'd6);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 5'(20 + i), 32'(i), 1, 5'd11, 32'hbbbb, 0, 0);
        drive(1, 1, 5'd24, 32'h24, 1, 5'd11, 32'hbbbb, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic obeying the stall and valid-hold contracts
        rpwe = 1'b0; rpa = '0; rpd = '0;
        rlv  = 1'b0; rla = '0; rld = '0;
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                rpwe = ($urandom_range(0, 3) != 0);
                rpa  = 5'($urandom_range(0, 7));
                rpd  = $urandom;
            end
            if (!rlv || last_rdy) begin
                rlv = ($urandom_range(0, 2) == 0);
                rla = 5'($urandom_range(0, 7));
                rld = $urandom;
            end
            drive(($urandom_range(0, 149) == 0), rpwe, rpa, rpd, rlv, rla, rld,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            if (d_rst) rlv = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #3;
        chk("queue drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
